// File: rtl/count_arbiter_pkg.sv
// Shared types and constants for the round-robin counter arbiter.
// Holds the arbiter state encoding, counter width and the ring-pointer helper.
package count_arbiter_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;
  localparam int OWN_W = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Advance a requester index around a ring of n entries.
  function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] idx, input int n);
    if (idx == OWN_W'(n - 1)) begin
      return '0;
    end
    return idx + OWN_W'(1);
  endfunction

endpackage

// File: rtl/count_arbiter_if.sv
// Request/grant and counter-observation bundle between requesters and the arbiter.
// master = requester side (drives req/req_num), slave = arbiter side.
interface count_arbiter_if #(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]                        req;
  logic [count_arbiter_pkg::CNT_W*NREQ-1:0] req_num;
  logic [NREQ-1:0]                        gnt;
  logic [NREQ-1:0]                        done;
  logic [count_arbiter_pkg::OWN_W-1:0]    owner;
  logic                                   busy;
  logic [count_arbiter_pkg::CNT_W-1:0]    number;
  logic                                   zero;

  modport master (
    output req, req_num,
    input  gnt, done, owner, busy, number, zero
  );

  modport slave (
    input  req, req_num,
    output gnt, done, owner, busy, number, zero
  );

endinterface

// File: rtl/count_arbiter_core.sv
// Free-running 4-bit counter with synchronous load, a one-cycle-delayed copy (number)
// and a zero flag decoded from that delayed copy.
module count_core
  import count_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [CNT_W-1:0] set_num,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] number,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] number_q, number_d;

  always_comb begin
    count_d  = count_q + CNT_W'(1);
    number_d = count_q;
    if (set) begin
      count_d = set_num;
    end else if (count_q == CNT_MAX) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      number_q <= '0;
    end else begin
      count_q  <= count_d;
      number_q <= number_d;
    end
  end

  assign count  = count_q;
  assign number = number_q;
  // Gated by rst_n so the flag reads low for the whole reset window.
  assign zero   = rst_n & (number_q == '0);

endmodule

// File: rtl/count_arbiter.sv
// Round-robin arbiter granting ownership of a shared counter; the owner loads it,
// done pulses on the 15->0 wrap, dropping req aborts ownership without done.
module count_arbiter
  import count_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst_n,
  count_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;

  logic [MAX_REQ-1:0]       req_ext;
  logic [CNT_W*MAX_REQ-1:0] req_num_ext;
  logic [MAX_REQ-1:0]       gnt_ext, done_ext;
  logic [OWN_W-1:0]         scan_idx, win_idx;
  logic                     win_found;
  logic                     set;
  logic [CNT_W-1:0]         set_num;
  logic [CNT_W-1:0]         count;

  // Widen to the maximum requester count so every index is exactly sized.
  always_comb begin
    req_ext                   = '0;
    req_ext[NREQ-1:0]         = bus.req;
    req_num_ext               = '0;
    req_num_ext[CNT_W*NREQ-1:0] = bus.req_num;
  end

  // First requesting index at or after the pointer, wrapping around the ring.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_ext[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = next_idx(scan_idx, NREQ);
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    gnt_ext  = '0;
    done_ext = '0;
    set      = 1'b0;
    set_num  = req_num_ext[{win_idx, 2'b00} +: CNT_W];
    case (state_q)
      IDLE: begin
        if (win_found) begin
          set              = 1'b1;
          gnt_ext[win_idx] = 1'b1;
          owner_d          = win_idx;
          ptr_d            = next_idx(win_idx, NREQ);
          state_d          = OWN;
        end
      end
      OWN: begin
        // Abort is checked first so a simultaneous drop and wrap gives no done.
        if (!req_ext[owner_q]) begin
          state_d = IDLE;
        end else if (count == CNT_MAX) begin
          done_ext[owner_q] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d  = gnt_ext[NREQ-1:0];
    done_d = done_ext[NREQ-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  count_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (set),
    .set_num (set_num),
    .count   (count),
    .number  (bus.number),
    .zero    (bus.zero)
  );

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == OWN);

endmodule
